// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared Ascon state type and inverse-diffusion constants
//
// Purpose:
//   Types and constants shared by the permutation datapath and the inverse
//   diffusion block.
//   - type_state     : five 64-bit words. Word i is state[i].
//   - INV_STEPS      : number of passes needed to invert the linear layer.
//   - type_inv_state : control states of the iterative inverter.
//   - ROT_INV_A/B    : per-word, per-step rotation amounts (a_i*2^k) mod 64.
//   - rotr64         : rotate right by a 6-bit amount. An amount of 0 returns x.
package ascon_pack;

  typedef logic [4:0][63:0] type_state;

  localparam int INV_STEPS = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } type_inv_state;

  // L_i^(2^k) = 1 + R^(a*2^k) + R^(b*2^k) over GF(2)[R]/(R^64+1), so every
  // step is another diffusion pass with doubled amounts. Entries of 0 and
  // equal A/B pairs are intentional and must stay as plain table values.
  localparam logic [5:0] ROT_INV_A [0:4][0:5] = '{
    '{6'd19, 6'd38, 6'd12, 6'd24, 6'd48, 6'd32},
    '{6'd61, 6'd58, 6'd52, 6'd40, 6'd16, 6'd32},
    '{6'd1,  6'd2,  6'd4,  6'd8,  6'd16, 6'd32},
    '{6'd10, 6'd20, 6'd40, 6'd16, 6'd32, 6'd0 },
    '{6'd7,  6'd14, 6'd28, 6'd56, 6'd48, 6'd32}
  };

  localparam logic [5:0] ROT_INV_B [0:4][0:5] = '{
    '{6'd28, 6'd56, 6'd48, 6'd32, 6'd0,  6'd0 },
    '{6'd39, 6'd14, 6'd28, 6'd56, 6'd48, 6'd32},
    '{6'd6,  6'd12, 6'd24, 6'd48, 6'd32, 6'd0 },
    '{6'd17, 6'd34, 6'd4,  6'd8,  6'd16, 6'd32},
    '{6'd41, 6'd18, 6'd36, 6'd8,  6'd16, 6'd32}
  };

  // The doubled word makes rotation by 0 come out as x with no special case.
  function automatic logic [63:0] rotr64(input logic [63:0] x, input logic [5:0] n);
    logic [127:0] w;
    w = {x, x} >> n;
    return w[63:0];
  endfunction

endpackage

// File: rtl/inv_diffusion_step.sv
// rtl/inv_diffusion_step.sv - one table-driven inverse diffusion pass
//
// Purpose:
//   Combinational pass x ^ rotr(x, A[i][k]) ^ rotr(x, B[i][k]) on each of the
//   five words, where k is the step index. It is kept separate so unrolled
//   variants can chain several copies.
// Ports:
//   state_i  in   type_state  state entering this step
//   step_i   in   3           step index k, 0..5
//   state_o  out  type_state  state after this step
module inv_diffusion_step
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [2:0] step_i,
  output type_state  state_o
);

  for (genvar i = 0; i < 5; i++) begin : g_word
    assign state_o[i] = state_i[i]
                      ^ rotr64(state_i[i], ROT_INV_A[i][step_i])
                      ^ rotr64(state_i[i], ROT_INV_B[i][step_i]);
  end

endmodule

// File: rtl/inv_diffusion_layer.sv
// rtl/inv_diffusion_layer.sv - iterative inverse of the Ascon linear layer
//
// Purpose:
//   Recovers the pre-diffusion state by applying L^(2^0) through L^(2^5) in
//   six sequential cycles. One inversion takes 8 cycles from accept to
//   accept.
// Ports:
//   clock_i  in   1           rising-edge clock
//   reset_i  in   1           synchronous, active-high reset
//   start_i  in   1           request, sampled only while ready_o=1
//   state_i  in   type_state  diffused state, captured with start_i
//   ready_o  out  1           idle, a start will be accepted
//   done_o   out  1           one-cycle pulse, state_o holds the result
//   state_o  out  type_state  working register. It shows intermediate values
//                             while running and holds the result until the
//                             next accepted start.
module inv_diffusion_layer
  import ascon_pack::*;
(
  input  logic      clock_i,
  input  logic      reset_i,
  input  logic      start_i,
  input  type_state state_i,
  output logic      ready_o,
  output logic      done_o,
  output type_state state_o
);

  localparam logic [2:0] LAST_STEP = 3'(INV_STEPS - 1);

  type_inv_state r_fsm;
  logic [2:0]    r_step;
  type_state     r_work;
  logic          r_ready;
  logic          r_done;
  type_state     w_next;

  inv_diffusion_step u_step (
    .state_i (r_work),
    .step_i  (r_step),
    .state_o (w_next)
  );

  // ready/done are registered. ready is high exactly while in IDLE, and done
  // is high exactly while in DONE.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_fsm   <= IDLE;
      r_step  <= 3'd0;
      r_work  <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_work  <= state_i;
            r_step  <= 3'd0;
            r_ready <= 1'b0;
            r_fsm   <= RUN;
          end
        end
        RUN: begin
          r_work <= w_next;
          if (r_step == LAST_STEP) begin
            // Wrap to 0 so the counter never leaves 0..5.
            r_step <= 3'd0;
            r_done <= 1'b1;
            r_fsm  <= DONE;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_fsm   <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_fsm   <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign done_o  = r_done;
  assign state_o = r_work;

endmodule
